// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared widths and opcode constants for the 10-bit
//             phase-sequenced CPU core and its instruction-fetch unit.
//  Contents : INSTRUCTION_LEN, ADDR_LEN, and the jump opcodes that the
//             core's Jmux decode compares against IR[9:4].
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int INSTRUCTION_LEN = 10;
    localparam int ADDR_LEN        = 4;
    localparam int OPCODE_LEN      = 6;

    // Upper six IR bits hold the opcode; the low ADDR_LEN bits are the target.
    localparam logic [OPCODE_LEN-1:0] OP_JMP = 6'b00_0100;
    localparam logic [OPCODE_LEN-1:0] OP_JZ  = 6'b00_0101;
    localparam logic [OPCODE_LEN-1:0] OP_JNZ = 6'b00_0110;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/prog_store.sv
`default_nettype none
// ============================================================================
//  Module   : prog_store
//  Purpose  : Instruction storage array, one synchronous write port and one
//             asynchronous read port. Not reset; powers up all-zero.
//  Ports    : clk_i    - clock
//             we_i     - write enable
//             waddr_i  - write address
//             wdata_i  - write data
//             raddr_i  - asynchronous read address
//             rdata_o  - read data (combinational from raddr_i)
//  Revision : 1.0  initial release
// ============================================================================
module prog_store
    import cpu_pkg::*;
#(
    parameter int DATA_W = INSTRUCTION_LEN,
    parameter int ADDR_W = ADDR_LEN
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Power-up contents are all-zero; there is deliberately no reset path.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A same-edge write is not visible here until after the edge, so a
    // simultaneous IR load captures the old word.
    assign rdata_o = mem_q[raddr_i];

endmodule : prog_store
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Instruction-supply stage for the 10-bit phase-sequenced core.
//             Holds PC, the instruction store and IR; updates PC from the
//             core's PClocd/Jmux strobes; counts IR loads for debug.
//  Ports    : Clock    - sole clock, rising edge
//             Reset    - synchronous active-high; clears PC, FetchCnt, Fetched
//             PClocd   - PC update strobe
//             Jmux     - 1: PC+1, 0: PC <= IR[ADDR_LEN-1:0]
//             IRload   - IR <= store[PC]
//             ProgWE   - program-store write enable
//             ProgAddr - program-store write address
//             ProgData - program-store write data
//             IR       - instruction register
//             PC       - program counter
//             Fetched  - one-cycle pulse the cycle after an IR load
//             FetchCnt - saturating count of IR loads since Reset
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int INSTRUCTION_LEN_P = INSTRUCTION_LEN,
    parameter int ADDR_LEN_P        = ADDR_LEN,
    parameter int FETCH_CNT_LEN     = 8
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         PClocd,
    input  logic                         Jmux,
    input  logic                         IRload,
    input  logic                         ProgWE,
    input  logic [ADDR_LEN_P-1:0]        ProgAddr,
    input  logic [INSTRUCTION_LEN_P-1:0] ProgData,
    output logic [INSTRUCTION_LEN_P-1:0] IR,
    output logic [ADDR_LEN_P-1:0]        PC,
    output logic                         Fetched,
    output logic [FETCH_CNT_LEN-1:0]     FetchCnt
);

    // IR is never reset by Reset: the core derives its reset from IR==0,
    // so clearing IR would lock the CPU in reset. Power-up value is zero.
    logic [INSTRUCTION_LEN_P-1:0] ir_q = '0;
    logic [INSTRUCTION_LEN_P-1:0] ir_d;
    logic [ADDR_LEN_P-1:0]        pc_q, pc_d;
    logic                         fetched_q, fetched_d;
    logic [FETCH_CNT_LEN-1:0]     cnt_q, cnt_d;
    logic [INSTRUCTION_LEN_P-1:0] store_rdata;

    prog_store #(
        .DATA_W (INSTRUCTION_LEN_P),
        .ADDR_W (ADDR_LEN_P)
    ) u_prog_store (
        .clk_i   (Clock),
        .we_i    (ProgWE),
        .waddr_i (ProgAddr),
        .wdata_i (ProgData),
        .raddr_i (pc_q),
        .rdata_o (store_rdata)
    );

    always_comb begin
        ir_d      = ir_q;
        pc_d      = pc_q;
        fetched_d = 1'b0;
        cnt_d     = cnt_q;

        // IR load is honoured regardless of Reset.
        if (IRload) begin
            ir_d = store_rdata;
        end

        if (Reset) begin
            pc_d  = '0;
            cnt_d = '0;
        end else begin
            fetched_d = IRload;
            if (IRload && (cnt_q != {FETCH_CNT_LEN{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
            // Jump target comes from IR before this edge, so a same-cycle
            // IR load does not affect where PC goes.
            if (PClocd) begin
                pc_d = Jmux ? (pc_q + 1'b1) : ir_q[ADDR_LEN_P-1:0];
            end
        end
    end

    always_ff @(posedge Clock) begin
        ir_q      <= ir_d;
        pc_q      <= pc_d;
        fetched_q <= fetched_d;
        cnt_q     <= cnt_d;
    end

    assign IR       = ir_q;
    assign PC       = pc_q;
    assign Fetched  = fetched_q;
    assign FetchCnt = cnt_q;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Scoreboard bench for instr_fetch_unit. Stimulus drives inputs
//             on the falling edge and pushes the model's expected post-edge
//             outputs; a monitor pops and compares after each rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       PClocd = 1'b0;
    logic       Jmux = 1'b0;
    logic       IRload = 1'b0;
    logic       ProgWE = 1'b0;
    logic [3:0] ProgAddr = '0;
    logic [9:0] ProgData = '0;
    logic [9:0] IR;
    logic [3:0] PC;
    logic       Fetched;
    logic [7:0] FetchCnt;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .Clock    (clk),
        .Reset    (Reset),
        .PClocd   (PClocd),
        .Jmux     (Jmux),
        .IRload   (IRload),
        .ProgWE   (ProgWE),
        .ProgAddr (ProgAddr),
        .ProgData (ProgData),
        .IR       (IR),
        .PC       (PC),
        .Fetched  (Fetched),
        .FetchCnt (FetchCnt)
    );

    typedef struct {
        int ir;
        int pc;
        int fetched;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state, plain integers.
    int m_mem[16];
    int m_ir  = 0;
    int m_pc  = 0;
    int m_fet = 0;
    int m_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, queue expectation.
    task automatic step(input bit rst, input bit pcl, input bit jm, input bit irl,
                        input bit we, input int addr, input int data);
        int old_pc, old_ir;
        exp_t e;
        @(negedge clk);
        Reset    = rst;
        PClocd   = pcl;
        Jmux     = jm;
        IRload   = irl;
        ProgWE   = we;
        ProgAddr = 4'(addr);
        ProgData = 10'(data);

        old_pc = m_pc;
        old_ir = m_ir;
        if (irl) m_ir = m_mem[old_pc];
        if (rst) begin
            m_pc  = 0;
            m_cnt = 0;
            m_fet = 0;
        end else begin
            if (pcl) m_pc = jm ? (old_pc + 1) % 16 : old_ir % 16;
            if (irl) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_fet = irl ? 1 : 0;
        end
        if (we) m_mem[addr] = data;

        e.ir = m_ir; e.pc = m_pc; e.fetched = m_fet; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int addr, input int data);
        step(0, 0, 0, 0, 1, addr, data);
    endtask

    // Monitor: the DUT presents new outputs every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("IR",       int'(IR),       e.ir);
                check("PC",       int'(PC),       e.pc);
                check("Fetched",  int'(Fetched),  e.fetched);
                check("FetchCnt", int'(FetchCnt), e.cnt);
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 0;

        #1;
        check("IR_power_up", int'(IR), 0);

        // Fill store and basic fetch.
        wr(0, 'h201); wr(1, 'h302); wr(2, 'h0FF); wr(3, 'h04A);
        wr(10, 'h155); wr(11, 'h00F);
        step(1, 0, 0, 0, 0, 0, 0);           // reset
        step(0, 0, 0, 1, 0, 0, 0);           // IR=0x201, Fetched next
        idle(); idle();                      // Fetched must drop

        // Sequential increments, then JMP 10 and fetch.
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);           // PC=3
        step(0, 0, 0, 1, 0, 0, 0);           // IR=0x04A
        step(0, 1, 0, 0, 0, 0, 0);           // PC=10
        step(0, 0, 0, 1, 0, 0, 0);           // IR=0x155
        // Reach PC=15 and wrap.
        step(0, 1, 1, 0, 0, 0, 0);           // PC=11
        step(0, 0, 0, 1, 0, 0, 0);           // IR=0x00F
        step(0, 1, 0, 0, 0, 0, 0);           // PC=15
        step(0, 1, 1, 0, 0, 0, 0);           // PC=0
        // PClocd low: Jmux ignored.
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // IR load while Reset is held.
        wr(0, 'h000);
        step(1, 0, 0, 1, 0, 0, 0);           // IR=0
        wr(0, 'h3FF);
        step(1, 1, 1, 1, 0, 0, 0);           // IR=0x3FF, PC stays 0, cnt 0
        idle();

        // Same-cycle IR load, jump and store write at PC.
        wr(0, 'h045); wr(5, 'h040);
        step(0, 0, 0, 1, 0, 0, 0);           // IR=0x045
        step(0, 1, 0, 1, 1, 0, 'h111);       // IR=0x045 (old), PC=5
        step(0, 0, 0, 1, 0, 0, 0);           // IR=0x040
        step(0, 1, 0, 0, 0, 0, 0);           // PC=0
        step(0, 0, 0, 1, 0, 0, 0);           // IR=0x111

        // Counter saturation and clear.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(0, 0, 0, 1, 0, 0, 0);
        idle(); idle();
        step(1, 0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 1023)));
        end
        idle();

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
